// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the FD/DE pipeline hazard controller: FSM encodings,
// counter and register-address widths, and the flash-count saturation helper.
package pipeline_hazard_ctrl_pkg;

    localparam int CNT_W  = 4;
    localparam int REG_AW = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN     = 2'd0;
    localparam state_t ST_FLUSH   = 2'd1;
    localparam state_t ST_INT_SEQ = 2'd2;

    // Interrupt entry pushes PC and flags through DE before the vector fetch.
    localparam logic [CNT_W-1:0] INT_PUSH_STEPS = 4'd2;

    function automatic logic [1:0] sat_flash(input logic [CNT_W-1:0] v);
        logic [1:0] r;
        if (v > CNT_W'(2'd3)) begin
            r = 2'd3;
        end else begin
            r = v[1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard bus: DE/FD operand info and branch/interrupt requests in,
// PC/FD/DE stall, bubble and flush controls out.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic              de_mr;
    logic              de_rw;
    logic [REG_AW-1:0] de_rd;
    logic [REG_AW-1:0] fd_rs;
    logic [REG_AW-1:0] fd_rt;
    logic              fd_use_rs;
    logic              fd_use_rt;
    logic              br_taken;
    logic              int_req;

    logic              pc_stall;
    logic              fd_stall;
    logic              de_bubble;
    logic              fd_flush;
    logic              de_flush;
    logic [1:0]        flash_num;
    logic              int_ack;
    logic [CNT_W-1:0]  int_step;

    modport master (
        output de_mr, de_rw, de_rd, fd_rs, fd_rt, fd_use_rs, fd_use_rt,
               br_taken, int_req,
        input  pc_stall, fd_stall, de_bubble, fd_flush, de_flush,
               flash_num, int_ack, int_step
    );

    modport slave (
        input  de_mr, de_rw, de_rd, fd_rs, fd_rt, fd_use_rs, fd_use_rt,
               br_taken, int_req,
        output pc_stall, fd_stall, de_bubble, fd_flush, de_flush,
               flash_num, int_ack, int_step
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Load-use detector: a DE load whose destination feeds a source operand of
// the instruction in FD. Purely combinational so it can serve a forwarding unit.
module pipeline_hazard_ctrl_hazard_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic              de_mr,
    input  logic              de_rw,
    input  logic [REG_AW-1:0] de_rd,
    input  logic [REG_AW-1:0] fd_rs,
    input  logic [REG_AW-1:0] fd_rt,
    input  logic              fd_use_rs,
    input  logic              fd_use_rt,
    output logic              lu
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = fd_use_rs & (fd_rs == de_rd);
    assign rt_hit_s = fd_use_rt & (fd_rt == de_rd);
    assign lu       = de_mr & de_rw & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer beside decode: one bubble per load-use hazard,
// a timed FD/DE flush after taken branches, and the interrupt-entry sequence.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int INT_CYCLES   = 3
) (
    input  logic                  Clk,
    input  logic                  Rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(INT_CYCLES - 1);
    localparam logic [1:0]       FLUSH_NUM  = sat_flash(CNT_W'(FLUSH_CYCLES));

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             int_pend_r;
    logic             int_pend_nxt_s;
    logic             lu_s;

    logic             pc_stall_s;
    logic             fd_stall_s;
    logic             de_bubble_s;
    logic             fd_flush_s;
    logic             de_flush_s;
    logic [1:0]       flash_num_s;
    logic             int_ack_s;
    logic [CNT_W-1:0] int_step_s;

    pipeline_hazard_ctrl_hazard_cmp u_hazard_cmp (
        .de_mr     (hz.de_mr),
        .de_rw     (hz.de_rw),
        .de_rd     (hz.de_rd),
        .fd_rs     (hz.fd_rs),
        .fd_rt     (hz.fd_rt),
        .fd_use_rs (hz.fd_use_rs),
        .fd_use_rt (hz.fd_use_rt),
        .lu        (lu_s)
    );

    // Next-state, counter and same-cycle pipeline controls.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        int_pend_nxt_s = int_pend_r | hz.int_req;
        pc_stall_s     = 1'b0;
        fd_stall_s     = 1'b0;
        de_bubble_s    = 1'b0;
        fd_flush_s     = 1'b0;
        de_flush_s     = 1'b0;
        flash_num_s    = 2'd0;
        int_ack_s      = 1'b0;
        int_step_s     = {CNT_W{1'b0}};

        case (state_r)
            ST_RUN: begin
                if (hz.br_taken) begin
                    fd_flush_s  = 1'b1;
                    de_flush_s  = 1'b1;
                    flash_num_s = FLUSH_NUM;
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = FLUSH_LOAD;
                end else if (lu_s) begin
                    // Interrupt entry waits for the bubble; the request stays pending.
                    pc_stall_s  = 1'b1;
                    fd_stall_s  = 1'b1;
                    de_bubble_s = 1'b1;
                end else if (hz.int_req | int_pend_r) begin
                    fd_flush_s     = 1'b1;
                    state_nxt_s    = ST_INT_SEQ;
                    cnt_nxt_s      = {CNT_W{1'b0}};
                    int_pend_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            ST_FLUSH: begin
                fd_flush_s  = 1'b1;
                de_flush_s  = 1'b1;
                flash_num_s = sat_flash(cnt_r);
                if (hz.br_taken) begin
                    cnt_nxt_s = FLUSH_LOAD;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1'b1);
                end
            end
            ST_INT_SEQ: begin
                pc_stall_s  = 1'b1;
                fd_stall_s  = 1'b1;
                // The PC and flag pushes must travel through DE, so no bubble then.
                de_bubble_s = (cnt_r >= INT_PUSH_STEPS);
                int_step_s  = cnt_r;
                if (cnt_r == INT_LAST) begin
                    int_ack_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, sequence counter and pending-interrupt flag.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r    <= ST_RUN;
            cnt_r      <= {CNT_W{1'b0}};
            int_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            int_pend_r <= int_pend_nxt_s;
        end
    end

    assign hz.pc_stall  = pc_stall_s;
    assign hz.fd_stall  = fd_stall_s;
    assign hz.de_bubble = de_bubble_s;
    assign hz.fd_flush  = fd_flush_s;
    assign hz.de_flush  = de_flush_s;
    assign hz.flash_num = flash_num_s;
    assign hz.int_ack   = int_ack_s;
    assign hz.int_step  = int_step_s;

endmodule
